vga_sync_rx: RTL and testbench
==============================

// Module: vga_sync_rx
// PURPOSE
//  Receive side of the 640x480 VGA link. Samples incoming hsync/vsync/valid/RGB and recovers
//  pixel coordinates. Measures the line and frame periods and reports lock against the
//  nominal 800x525 timing. Sits between an external VGA source (or loopback from our timing
//  generator) and the frame-capture/checker logic.
// PARAMETERS
//  H_TOTAL      800  pclk cycles between successive hsync falling edges
//  V_TOTAL      525  hsync falling edges between successive vsync falling edges
//  H_ACTIVE     640  max valid pixels per line
//  V_ACTIVE     480  max lines carrying valid pixels per frame
//  LOCK_FRAMES  2    consecutive clean frames required before locked=1 (1..15)
// PORTS
//  pclk         in   1   25 MHz pixel clock
//  reset        in   1   asynchronous, active-high
//  in_hsync     in   1   line sync, active-low pulse
//  in_vsync     in   1   frame sync, active-low pulse
//  in_valid     in   1   active-video (blanking when 0)
//  in_rgb       in   24  {R[23:16],G[15:8],B[7:0]}
//  pix_valid    out  1   pix_x/pix_y/pix_data valid this cycle
//  pix_x        out  10  column of pixel, 0..H_ACTIVE-1
//  pix_y        out  10  row of pixel, 0..V_ACTIVE-1
//  pix_data     out  24  in_rgb delayed
//  frame_start  out  1   1-cycle pulse on vsync falling edge
//  locked       out  1   timing matches H_TOTAL/V_TOTAL
//  timing_err   out  1   1-cycle pulse on period mismatch while VERIFY/LOCKED
//  overrun_err  out  1   1-cycle pulse on valid pixel beyond H_ACTIVE or V_ACTIVE
//  h_meas       out  11  last measured line period (saturates 2047)
//  v_meas       out  10  last measured frame period in lines (saturates 1023)
//  frame_sum    out  24  per-frame pixel checksum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; sync sample regs reset to 1 (idle) -> no false edge on release; FSM=SEARCH.
//  - Stage 1 registers all inputs. Edges are detected from stage-1 value vs its previous value.
//    Outputs are registered from stage 1 -> latency 2 pclk from input to pix_* / frame_start.
//  - hfall = hsync 1->0; vfall = vsync 1->0.
//  - h counter: counts pclk; on hfall, h_meas <= cycles since previous hfall, counter restarts.
//  - v counter: counts hfall; on vfall, v_meas <= hfalls since previous vfall (the hfall coincident
//    with vfall counts toward the new frame).
//  - Coordinates: xcnt cleared on hfall. Each valid sample: pix_x<=xcnt, pix_y<=ycnt, xcnt++.
//    ycnt increments on hfall only if the ending line had >=1 valid pixel; ycnt cleared on vfall.
//    Simultaneous hfall+vfall: vfall wins (ycnt=0, line flag cleared, xcnt=0).
//  - Overrun: valid sample with xcnt>=H_ACTIVE or ycnt>=V_ACTIVE -> pix_valid=0, overrun_err pulse;
//    xcnt does not advance past H_ACTIVE.
//  - pix_valid is not gated by locked.
//  - Lock FSM:
//    SEARCH: wait for vfall -> VERIFY, good=0.
//    VERIFY: hfall with h_meas!=H_TOTAL -> SEARCH + timing_err.
//            vfall: v_meas!=V_TOTAL -> SEARCH + timing_err; else good++.
//            good reaches LOCK_FRAMES -> LOCKED.
//    LOCKED: locked=1; any h/v mismatch -> SEARCH, locked=0 next cycle, timing_err pulse.
//    The hfall measurement at the SEARCH->VERIFY vfall is ignored.
//  - Reset mid-frame: everything returns to reset state. No frame_start or lock progress until
//    the next vfall.
// CONFIGURATION
//  VGA_RX_CHECKSUM_EN defined:
//    - 24-bit accumulator adds pix_data (mod 2^24) on each pix_valid.
//    - On vfall, frame_sum <= accumulator (including a pixel accepted that same cycle) and the
//      accumulator clears.
//  Undefined: no accumulator; frame_sum tied to 0.
// TESTING
//  1 Nominal 800x525 stream, LOCK_FRAMES=2 -> locked=1 two pclk after the 3rd vfall at input.
//    pix_x spans 0..639, pix_y spans 0..479, pix_data==in_rgb delayed 2, h_meas=800, v_meas=525.
//  2 While locked, one line of 799 clocks -> timing_err pulse and locked=0.
//    Relock after 3 further clean vfalls.
//  3 Line with 641 valid samples -> 641st gives pix_valid=0 and overrun_err=1; last pix_x=639.
//  4 reset pulsed mid-line -> all outputs 0 during reset; after release no frame_start until next vfall.
//  5 hsync and vsync fall same cycle -> one frame_start pulse; first active line reports pix_y=0.
//  6 VGA_RX_CHECKSUM_EN, full frame of 0x000001 -> frame_sum=0x04B000 after following vfall.
//    Without the macro -> frame_sum=0.

Source files
------------

// File: rtl/vga_sync_rx_if.sv
// Bundle of the VGA receive link: sampled sync/video inputs and recovered pixel/status outputs.
interface vga_sync_rx_if;
  localparam int unsigned DW = 24;
  localparam int unsigned CW = 10;
  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;

  logic          in_hsync;
  logic          in_vsync;
  logic          in_valid;
  logic [DW-1:0] in_rgb;

  logic          pix_valid;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic [DW-1:0] pix_data;
  logic          frame_start;
  logic          locked;
  logic          timing_err;
  logic          overrun_err;
  logic [HW-1:0] h_meas;
  logic [VW-1:0] v_meas;
  logic [DW-1:0] frame_sum;

  modport master (
    output in_hsync, in_vsync, in_valid, in_rgb,
    input  pix_valid, pix_x, pix_y, pix_data, frame_start, locked,
    input  timing_err, overrun_err, h_meas, v_meas, frame_sum
  );

  modport slave (
    input  in_hsync, in_vsync, in_valid, in_rgb,
    output pix_valid, pix_x, pix_y, pix_data, frame_start, locked,
    output timing_err, overrun_err, h_meas, v_meas, frame_sum
  );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA receive front end: samples the link, recovers pixel coordinates and tracks line/frame lock.
// Define VGA_RX_CHECKSUM_EN to enable the per-frame pixel checksum on frame_sum (else tied to 0).
module vga_sync_rx #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic         pclk,
  input  logic         reset,
  vga_sync_rx_if.slave vif
);
  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int unsigned CW = 10;
  localparam int unsigned DW = 24;
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  logic          hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, valid_s1_q, valid_s1_d;
  logic [DW-1:0] rgb_s1_q, rgb_s1_d;
  logic          hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [HW-1:0] hcnt_q, hcnt_d, h_meas_q, h_meas_d;
  logic [VW-1:0] vcnt_q, vcnt_d, v_meas_q, v_meas_d;
  logic [CW-1:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic          line_seen_q, line_seen_d;
  logic          pix_valid_q, pix_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          overrun_err_q, overrun_err_d;
  logic [DW-1:0] pix_data_q, pix_data_d, frame_sum_q, frame_sum_d;
  state_e        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic          locked_q, locked_d, timing_err_q, timing_err_d;
  logic          hfall, vfall, h_bad, v_bad, accept;
  logic [CW-1:0] x_eff, y_eff;
`ifdef VGA_RX_CHECKSUM_EN
  logic [DW-1:0] acc_q, acc_d;
`endif

  // Sampling, period measurement, coordinate recovery and checksum
  always_comb begin
    hs_s1_d    = vif.in_hsync;
    vs_s1_d    = vif.in_vsync;
    valid_s1_d = vif.in_valid;
    rgb_s1_d   = vif.in_rgb;
    hs_prev_d  = hs_s1_q;
    vs_prev_d  = vs_s1_q;

    hfall = hs_prev_q & ~hs_s1_q;
    vfall = vs_prev_q & ~vs_s1_q;

    hcnt_d   = (hcnt_q == '1) ? hcnt_q : hcnt_q + HW'(1);
    h_meas_d = h_meas_q;
    if (hfall) begin
      h_meas_d = hcnt_q;
      hcnt_d   = HW'(1);
    end

    vcnt_d   = vcnt_q;
    v_meas_d = v_meas_q;
    if (hfall && (vcnt_q != '1)) vcnt_d = vcnt_q + VW'(1);
    // The hfall coincident with vfall belongs to the new frame
    if (vfall) begin
      v_meas_d = vcnt_q;
      vcnt_d   = hfall ? VW'(1) : '0;
    end

    // Effective counters for this sample, after any line/frame restart
    x_eff = (hfall || vfall) ? '0 : xcnt_q;
    if (vfall)                                                  y_eff = '0;
    else if (hfall && line_seen_q && (ycnt_q < CW'(V_ACTIVE))) y_eff = ycnt_q + CW'(1);
    else                                                        y_eff = ycnt_q;

    accept = valid_s1_q && (x_eff < CW'(H_ACTIVE)) && (y_eff < CW'(V_ACTIVE));

    xcnt_d      = accept ? x_eff + CW'(1) : x_eff;
    ycnt_d      = y_eff;
    line_seen_d = ((hfall || vfall) ? 1'b0 : line_seen_q) | valid_s1_q;

    pix_valid_d   = accept;
    pix_x_d       = accept ? x_eff : pix_x_q;
    pix_y_d       = accept ? y_eff : pix_y_q;
    pix_data_d    = rgb_s1_q;
    frame_start_d = vfall;
    overrun_err_d = valid_s1_q && !accept;

`ifdef VGA_RX_CHECKSUM_EN
    acc_d       = accept ? acc_q + rgb_s1_q : acc_q;
    frame_sum_d = frame_sum_q;
    if (vfall) begin
      frame_sum_d = acc_d;
      acc_d       = '0;
    end
`else
    frame_sum_d = '0;
`endif
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hs_s1_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      valid_s1_q    <= 1'b0;
      rgb_s1_q      <= '0;
      hcnt_q        <= '0;
      h_meas_q      <= '0;
      vcnt_q        <= '0;
      v_meas_q      <= '0;
      xcnt_q        <= '0;
      ycnt_q        <= '0;
      line_seen_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      frame_start_q <= 1'b0;
      overrun_err_q <= 1'b0;
      frame_sum_q   <= '0;
`ifdef VGA_RX_CHECKSUM_EN
      acc_q         <= '0;
`endif
    end else begin
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      valid_s1_q    <= valid_s1_d;
      rgb_s1_q      <= rgb_s1_d;
      hcnt_q        <= hcnt_d;
      h_meas_q      <= h_meas_d;
      vcnt_q        <= vcnt_d;
      v_meas_q      <= v_meas_d;
      xcnt_q        <= xcnt_d;
      ycnt_q        <= ycnt_d;
      line_seen_q   <= line_seen_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      frame_start_q <= frame_start_d;
      overrun_err_q <= overrun_err_d;
      frame_sum_q   <= frame_sum_d;
`ifdef VGA_RX_CHECKSUM_EN
      acc_q         <= acc_d;
`endif
    end
  end

  // Lock tracking; the measurement coinciding with the SEARCH exit vfall is ignored
  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    timing_err_d = 1'b0;
    h_bad        = hfall && (hcnt_q != HW'(H_TOTAL));
    v_bad        = vfall && (vcnt_q != VW'(V_TOTAL));
    case (state_q)
      ST_SEARCH: begin
        if (vfall) begin
          state_d = ST_VERIFY;
          good_d  = '0;
        end
      end
      ST_VERIFY: begin
        if (h_bad || v_bad) begin
          state_d      = ST_SEARCH;
          timing_err_d = 1'b1;
        end else if (vfall) begin
          good_d = good_q + GW'(1);
          if (good_d == GW'(LOCK_FRAMES)) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (h_bad || v_bad) begin
          state_d      = ST_SEARCH;
          timing_err_d = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SEARCH;
      good_q       <= '0;
      locked_q     <= 1'b0;
      timing_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      locked_q     <= locked_d;
      timing_err_q <= timing_err_d;
    end
  end

  assign vif.pix_valid   = pix_valid_q;
  assign vif.pix_x       = pix_x_q;
  assign vif.pix_y       = pix_y_q;
  assign vif.pix_data    = pix_data_q;
  assign vif.frame_start = frame_start_q;
  assign vif.locked      = locked_q;
  assign vif.timing_err  = timing_err_q;
  assign vif.overrun_err = overrun_err_q;
  assign vif.h_meas      = h_meas_q;
  assign vif.v_meas      = v_meas_q;
  assign vif.frame_sum   = frame_sum_q;
endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a scaled-down 40x12 raster: frame table, random active lines,
// scoreboard of expected pixels built from the raster plan, and a mid-line reset sequence.
module tb_vga_sync_rx;
  localparam int HT      = 40;
  localparam int VT      = 12;
  localparam int HA      = 24;
  localparam int VA      = 8;
  localparam int LF      = 2;
  localparam int HS_LEN  = 4;
  localparam int V_START = 8;
  localparam int ACT0    = 3;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] d;
  } pix_t;

  typedef struct {
    int          short_line;
    int          ovr_line;
    bit          rnd;
    logic [23:0] cdata;
    bit          exp_lock;
  } frame_t;

  logic pclk = 1'b0;
  logic reset;
  vga_sync_rx_if vif();

  vga_sync_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .pclk (pclk),
    .reset(reset),
    .vif  (vif)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  pix_t exp_q[$];
  pix_t e;
  bit   mon_en = 1'b0;
  int   ovr_cnt = 0, fs_cnt = 0, terr_cnt = 0;
  int   exp_ovr = 0, exp_fs = 0, exp_terr_cnt = 0;
  int   prev_len = 0, lines_in_frame = 0, y_lines = 0;
  bit   vmeas_ok = 1'b0;
  logic [23:0] acc = '0;
  frame_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic any_output();
    return |{vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_data, vif.frame_start, vif.locked,
             vif.timing_err, vif.overrun_err, vif.h_meas, vif.v_meas, vif.frame_sum};
  endfunction

  // Scoreboard: every accepted pixel must match the next planned pixel
  always @(negedge pclk) begin
    if (mon_en && !reset) begin
      if (vif.pix_valid) begin
        if (exp_q.size() == 0) begin
          chk("pix_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pix_x", 64'(vif.pix_x), 64'(e.x));
          chk("pix_y", 64'(vif.pix_y), 64'(e.y));
          chk("pix_data", 64'(vif.pix_data), 64'(e.d));
        end
      end
      if (vif.overrun_err) ovr_cnt++;
      if (vif.frame_start) fs_cnt++;
      if (vif.timing_err)  terr_cnt++;
    end
  end

  task automatic drive_idle(input int n, input bit hs, input bit vs);
    for (int c = 0; c < n; c++) begin
      @(negedge pclk);
      vif.in_hsync = hs;
      vif.in_vsync = vs;
      vif.in_valid = 1'b0;
      vif.in_rgb   = 24'($urandom);
    end
  endtask

  // One raster line: hsync low for HS_LEN cycles, nvalid samples from V_START
  task automatic send_line(input int len, input int nvalid, input bit vs_low, input bit fs,
                           input bit rnd, input logic [23:0] cdata, input bit exp_lock,
                           input bit exp_terr);
    int hm, vm, ly, idx;
    bit v;
    logic [23:0] fsum, d;
    hm = prev_len;
    prev_len = len;
    vm = -1;
    fsum = '0;
    if (fs) begin
      if (vmeas_ok) vm = lines_in_frame;
      vmeas_ok = 1'b1;
      lines_in_frame = 0;
`ifdef VGA_RX_CHECKSUM_EN
      fsum = acc;
`else
      fsum = '0;
`endif
      acc = '0;
      y_lines = 0;
      exp_fs++;
    end
    if (exp_terr) exp_terr_cnt++;
    lines_in_frame++;
    ly = y_lines;
    for (int c = 0; c < len; c++) begin
      @(negedge pclk);
      if (c == 1) chk("timing_err_idle", 64'(vif.timing_err), 64'(0));
      if (c == 2) begin
        chk("frame_start", 64'(vif.frame_start), 64'(fs));
        chk("timing_err", 64'(vif.timing_err), 64'(exp_terr));
        chk("locked", 64'(vif.locked), 64'(exp_lock));
        if (hm > 0) chk("h_meas", 64'(vif.h_meas), 64'(hm));
        if (fs && vm >= 0) chk("v_meas", 64'(vif.v_meas), 64'(vm));
        if (fs) chk("frame_sum", 64'(vif.frame_sum), 64'(fsum));
      end
      if (c == 3) begin
        chk("frame_start_width", 64'(vif.frame_start), 64'(0));
        chk("timing_err_width", 64'(vif.timing_err), 64'(0));
      end
      d = rnd ? 24'($urandom) : cdata;
      v = (c >= V_START) && (c < V_START + nvalid);
      vif.in_hsync = (c >= HS_LEN);
      vif.in_vsync = !vs_low;
      vif.in_valid = v;
      vif.in_rgb   = d;
      if (v) begin
        idx = c - V_START;
        if (idx < HA && ly < VA) begin
          exp_q.push_back('{x: 10'(idx), y: 10'(ly), d: d});
          acc += d;
        end else begin
          exp_ovr++;
        end
      end
    end
    if (nvalid > 0) y_lines++;
  endtask

  task automatic send_frame(input frame_t f);
    bit lk, terr;
    int len, nv;
    lk = f.exp_lock;
    for (int l = 0; l < VT; l++) begin
      len  = (l == f.short_line) ? HT - 1 : HT;
      terr = (f.short_line >= 0) && (l == f.short_line + 1);
      if (terr) lk = 1'b0;
      if (l >= ACT0 && l < ACT0 + VA) begin
        if (l == f.ovr_line) nv = HA + 1;
        else if (f.rnd)      nv = int'($urandom_range(32'(HA + 1), 0));
        else                 nv = HA;
      end else begin
        nv = 0;
      end
      send_line(len, nv, l < 2, l == 0, f.rnd, f.cdata, lk, terr);
    end
  endtask

  initial begin
    logic [23:0] exp_full;
`ifdef VGA_RX_CHECKSUM_EN
    exp_full = 24'(HA * VA);
`else
    exp_full = 24'h0;
`endif
    // {short_line, ovr_line, rnd, cdata, locked after its vfall}
    tbl[0] = '{-1, -1, 1'b0, 24'h000001, 1'b0};
    tbl[1] = '{-1, -1, 1'b1, 24'h000000, 1'b0};
    tbl[2] = '{-1, -1, 1'b0, 24'h123456, 1'b1};
    tbl[3] = '{ 5, -1, 1'b0, 24'h0000ff, 1'b1};
    tbl[4] = '{-1, -1, 1'b0, 24'h000001, 1'b0};
    tbl[5] = '{-1, -1, 1'b1, 24'h000000, 1'b0};
    tbl[6] = '{-1,  4, 1'b0, 24'h00a5a5, 1'b1};
    tbl[7] = '{-1, -1, 1'b1, 24'h000000, 1'b1};
    tbl[8] = '{-1, -1, 1'b0, 24'h000001, 1'b1};

    reset = 1'b1;
    vif.in_hsync = 1'b1;
    vif.in_vsync = 1'b1;
    vif.in_valid = 1'b0;
    vif.in_rgb   = '0;
    repeat (3) @(negedge pclk);
    chk("reset_outputs", 64'(any_output()), 64'(0));
    reset = 1'b0;
    mon_en = 1'b1;

    for (int f = 0; f < 9; f++) send_frame(tbl[f]);

    // Frame interrupted by reset during its last (blank) line
    for (int l = 0; l < VT - 1; l++)
      send_line(HT, (l >= ACT0 && l < ACT0 + VA) ? HA : 0, l < 2, l == 0, 1'b0,
                24'h0f0f0f, 1'b1, 1'b0);
    chk("frame_sum_const", 64'(vif.frame_sum), 64'(exp_full));
    for (int c = 0; c < 12; c++) begin
      @(negedge pclk);
      vif.in_hsync = (c >= HS_LEN);
      vif.in_vsync = 1'b1;
      vif.in_valid = 1'b0;
    end
    @(negedge pclk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      chk("reset_midline_outputs", 64'(any_output()), 64'(0));
    end
    reset = 1'b0;
    prev_len = 0;
    lines_in_frame = 0;
    vmeas_ok = 1'b0;
    y_lines = 0;
    acc = '0;
    drive_idle(HT - 16, 1'b1, 1'b1);
    send_line(HT, 0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    send_line(HT, 0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    send_frame('{-1, -1, 1'b0, 24'h000002, 1'b0});
    send_line(HT, 0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    drive_idle(10, 1'b1, 1'b1);

    chk("pixels_pending", 64'(exp_q.size()), 64'(0));
    chk("overrun_count", 64'(ovr_cnt), 64'(exp_ovr));
    chk("frame_start_count", 64'(fs_cnt), 64'(exp_fs));
    chk("timing_err_count", 64'(terr_cnt), 64'(exp_terr_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
